yutorina_bus_arbiter: RTL and testbench
=======================================

Name: yutorina_bus_arbiter

Overview:
Round-robin bus arbiter and master-side multiplexer for the shared system bus. Four bus masters connect here: the CPU instruction port, the CPU data port, and two spare masters (DMA/debug). Each master uses the active-low req_/grnt_/as_/rdy_ protocol. The arbiter grants one owner at a time, routes the owner's address, strobe and write data to the slave side, and returns ready only to the owner. A watchdog aborts slave accesses that hang.

Parameters:
TIMEOUT, 255, cycles an access may wait for s_rdy_ before it is aborted; 0 disables the watchdog.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
m_req_  in  4  bus request per master, active-low
m_grnt_  out  4  bus grant per master, active-low, registered, one-hot-low
m_addr  in  4x30  packed word addresses; master i occupies bits [30i+29:30i]
m_as_  in  4  address strobe per master, active-low
m_rw  in  4  per master, 1 = read, 0 = write
m_w_data  in  4x32  packed write data; master i occupies bits [32i+31:32i]
m_rdy_  out  4  per-master ready, active-low, asserted to the owner only
m_r_data  out  32  read data, broadcast to all masters
s_addr  out  30  address to slave decoder
s_as_  out  1  strobe to slaves, active-low
s_rw  out  1  read/write to slaves
s_w_data  out  32  write data to slaves
s_rdy_  in  1  OR-combined slave ready, active-low
s_r_data  in  32  muxed slave read data
bus_err  out  1  one-cycle timeout pulse, registered
err_master  out  2  owner index latched at timeout

Behaviour:
- State:
  - owner[1:0] register.
  - Watchdog counter wd_cnt, width clog2(TIMEOUT+1).
  - to_hit flag register.
- Reset (rst=1 at a clk edge):
  - owner=0, m_grnt_=4'b1110 (bus parked on master 0).
  - wd_cnt=0, to_hit=0, bus_err=0, err_master=0.
  - Combinational outputs follow the reset owner: s_as_=m_as_[0]; m_rdy_[3:1]=1.
- Arbitration, evaluated every cycle:
  - If m_req_[owner]=0, the owner keeps the bus. There is no preemption, including after a timeout.
  - If m_req_[owner]=1, next owner is the first master with req_=0 in order owner+1, owner+2, owner+3 (mod 4).
  - If no master requests, owner is unchanged and the bus stays parked.
  - owner and m_grnt_ update at the clock edge, so grant latency is 1 cycle from req_ assertion on an idle bus.
- Master mux (combinational from owner):
  - s_addr=m_addr[owner], s_rw=m_rw[owner], s_w_data=m_w_data[owner].
  - s_as_=m_as_[owner], forced to 1 while to_hit=1.
  - Non-owner as_ is ignored.
- Return path (combinational):
  - m_rdy_[i]=s_rdy_ when i==owner, otherwise 1.
  - m_r_data=s_r_data.
  - While to_hit=1: m_rdy_[owner]=0 and m_r_data=32'h0, so the aborted access completes with zero data.
- Watchdog (TIMEOUT>0):
  - wd_cnt increments in each cycle where s_as_=0 and s_rdy_=1.
  - wd_cnt clears when s_rdy_=0, when s_as_=1, on an owner change, or when to_hit=1.
  - When wd_cnt==TIMEOUT-1 and the access is still waiting: to_hit<=1, bus_err<=1 and err_master<=owner at the next edge.
  - to_hit and bus_err last exactly 1 cycle.
  - TIMEOUT=0: wd_cnt stays 0 and to_hit/bus_err never assert.
- Boundaries:
  - Slave ready in the same cycle the watchdog would fire: the ready wins and no error is raised.
  - Owner drops req_ in the same cycle another master raises it: the handoff happens at the next edge.
  - All four request simultaneously from owner=0: grants go 1, 2, 3, 0 as each releases.
  - rst mid-transfer: the bus returns to master 0 immediately and any in-flight access is abandoned with no rdy_ or error.

Decomposition:
- Shared bus header:
  - BusMasterCh=4 and BusOwnerBus=[1:0].
  - WordAddrBus/WordDataBus widths (30/32).
  - Active-low enable/disable level constants.
- One sub-module, yutorina_bus_watchdog: wd_cnt, to_hit, bus_err, err_master.
- Arbitration and the mux stay in the top module.

Test Plan:
- Reset: rst=1 for 2 cycles -> m_grnt_=4'b1110, bus_err=0, m_rdy_[3:1]=1. With m_as_[0]=0 and m_addr[0]=30'h10: s_addr=30'h10, s_as_=0.
- Single request: master 0 idle (req_=1), master 2 drops req_ at cycle t -> m_grnt_=4'b1011 at t+1. Then s_addr=m_addr[2], and a s_rdy_=0 pulse reaches only m_rdy_[2].
- Round robin: owner=0; masters 0-3 all drop req_; each owner releases req_ for one cycle after one transfer -> grant sequence 0, 1, 2, 3, 0, each handoff 1 cycle after release.
- Hold: master 1 owns and keeps req_=0 for 50 cycles while masters 2 and 3 request -> m_grnt_ stays 4'b1101 for all 50 cycles.
- Timeout, TIMEOUT=8: owner 3 drives s_as_=0 and the slave never drives s_rdy_.
  - 9th cycle after the strobe: m_rdy_[3]=0, m_r_data=0, s_as_=1, bus_err=1, err_master=3 for exactly 1 cycle.
  - Repeat with s_rdy_=0 on the 8th cycle -> no error.
- Reset mid-transfer: owner 2 waiting on a slave, rst=1 for 1 cycle -> m_grnt_=4'b1110, wd_cnt=0, and no bus_err follows.

Source files
------------

// File: rtl/yutorina_bus_arbiter_pkg.sv
// yutorina_bus_arbiter_pkg: shared bus widths, master count and active-low levels
package yutorina_bus_arbiter_pkg;
    localparam int BusMasterCh = 4;
    localparam int BusOwnerW = 2;
    localparam int WordAddrW = 30;
    localparam int WordDataW = 32;
    localparam logic Enable_ = 1'b0;
    localparam logic Disable_ = 1'b1;
endpackage

// File: rtl/yutorina_bus_watchdog.sv
// yutorina_bus_watchdog: aborts a slave access that waits TIMEOUT cycles for ready
module yutorina_bus_watchdog
    import yutorina_bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_as_,
    input  logic                 s_rdy_,
    input  logic [BusOwnerW-1:0] owner,
    input  logic                 owner_chg,
    output logic                 to_hit,
    output logic                 bus_err,
    output logic [BusOwnerW-1:0] err_master
);
    localparam int W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int Lim = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    logic [W-1:0] wd_cnt;
    logic waiting, fire;
    // A ready in the firing cycle makes waiting false, so the slave wins the race
    assign waiting = (s_as_ == Enable_) && (s_rdy_ == Disable_) && !owner_chg && !to_hit;
    assign fire = (TIMEOUT > 0) && waiting && (wd_cnt == W'(Lim));
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt <= '0;
            to_hit <= 1'b0;
            bus_err <= 1'b0;
            err_master <= '0;
        end else begin
            wd_cnt <= (waiting && TIMEOUT > 0) ? wd_cnt + 1'b1 : '0;
            to_hit <= fire;
            bus_err <= fire;
            if (fire) err_master <= owner;
        end
    end
endmodule

// File: rtl/yutorina_bus_arbiter.sv
// yutorina_bus_arbiter: round-robin arbiter and master-side mux for the shared bus
module yutorina_bus_arbiter
    import yutorina_bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [BusMasterCh-1:0]           m_req_,
    output logic [BusMasterCh-1:0]           m_grnt_,
    input  logic [BusMasterCh*WordAddrW-1:0] m_addr,
    input  logic [BusMasterCh-1:0]           m_as_,
    input  logic [BusMasterCh-1:0]           m_rw,
    input  logic [BusMasterCh*WordDataW-1:0] m_w_data,
    output logic [BusMasterCh-1:0]           m_rdy_,
    output logic [WordDataW-1:0]             m_r_data,
    output logic [WordAddrW-1:0]             s_addr,
    output logic                             s_as_,
    output logic                             s_rw,
    output logic [WordDataW-1:0]             s_w_data,
    input  logic                             s_rdy_,
    input  logic [WordDataW-1:0]             s_r_data,
    output logic                             bus_err,
    output logic [BusOwnerW-1:0]             err_master
);
    logic [BusOwnerW-1:0] owner, owner_nx;
    logic to_hit;
    // Scan downwards so the nearest requester after the owner wins
    always_comb begin
        owner_nx = owner;
        if (m_req_[owner] == Disable_)
            for (int k = BusMasterCh - 1; k > 0; k--)
                if (m_req_[owner + BusOwnerW'(k)] == Enable_) owner_nx = owner + BusOwnerW'(k);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            owner <= '0;
            m_grnt_ <= 4'b1110;
        end else begin
            owner <= owner_nx;
            m_grnt_ <= ~(4'b0001 << owner_nx);
        end
    end
    assign s_addr = m_addr[owner*WordAddrW +: WordAddrW];
    assign s_w_data = m_w_data[owner*WordDataW +: WordDataW];
    assign s_rw = m_rw[owner];
    assign s_as_ = to_hit ? Disable_ : m_as_[owner];
    assign m_r_data = to_hit ? '0 : s_r_data;
    always_comb begin
        m_rdy_ = '1;
        m_rdy_[owner] = to_hit ? Enable_ : s_rdy_;
    end
    yutorina_bus_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
        .clk(clk),
        .rst(rst),
        .s_as_(s_as_),
        .s_rdy_(s_rdy_),
        .owner(owner),
        .owner_chg(owner_nx != owner),
        .to_hit(to_hit),
        .bus_err(bus_err),
        .err_master(err_master)
    );
endmodule

// File: tb/tb_yutorina_bus_arbiter.sv
// tb_yutorina_bus_arbiter: directed scoreboard bench for the round-robin bus arbiter
module tb_yutorina_bus_arbiter;
    logic clk = 1'b0;
    logic rst;
    logic [3:0] m_req_, m_grnt_, m_as_, m_rw, m_rdy_;
    logic [119:0] m_addr;
    logic [127:0] m_w_data;
    logic [31:0] m_r_data, s_w_data, s_r_data;
    logic [29:0] s_addr;
    logic s_as_, s_rw, s_rdy_, bus_err;
    logic [1:0] err_master;
    int errors = 0;
    int checks = 0;

    typedef struct {
        string tag;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];

    yutorina_bus_arbiter #(.TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .m_req_(m_req_), .m_grnt_(m_grnt_), .m_addr(m_addr), .m_as_(m_as_),
        .m_rw(m_rw), .m_w_data(m_w_data), .m_rdy_(m_rdy_), .m_r_data(m_r_data),
        .s_addr(s_addr), .s_as_(s_as_), .s_rw(s_rw), .s_w_data(s_w_data),
        .s_rdy_(s_rdy_), .s_r_data(s_r_data), .bus_err(bus_err), .err_master(err_master)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic got(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed %0h with no required value queued", obs);
            return;
        end
        e = sb.pop_front();
        assert (obs === e.val) else begin
            errors++;
            $error("FAIL %s: observed %0h required %0h", e.tag, obs, e.val);
        end
    endtask

    initial begin
        rst = 1'b1;
        m_req_ = 4'hF;
        m_as_ = 4'hF;
        m_rw = 4'b0101;
        s_rdy_ = 1'b1;
        s_r_data = 32'hDEADBEEF;
        for (int i = 0; i < 4; i++) begin
            m_addr[i*30 +: 30] = 30'h10 + 30'(i * 'h100);
            m_w_data[i*32 +: 32] = 32'hA0 + 32'(i);
        end
        tick();
        tick();
        rst = 1'b0;
        expect_val("reset_grant", 32'hE);
        got({28'h0, m_grnt_});
        expect_val("reset_bus_err", 32'h0);
        got({31'h0, bus_err});
        expect_val("reset_rdy_hi", 32'h7);
        got({29'h0, m_rdy_[3:1]});
        m_as_[0] = 1'b0;
        #1;
        expect_val("reset_s_addr", 32'h10);
        got({2'h0, s_addr});
        expect_val("reset_s_as", 32'h0);
        got({31'h0, s_as_});
        m_as_[0] = 1'b1;

        m_req_[2] = 1'b0;
        expect_val("single_grant", 32'hB);
        tick();
        got({28'h0, m_grnt_});
        expect_val("single_s_addr", 32'h210);
        got({2'h0, s_addr});
        expect_val("single_w_data", 32'hA2);
        got(s_w_data);
        expect_val("single_rw", 32'h1);
        got({31'h0, s_rw});
        s_rdy_ = 1'b0;
        #1;
        expect_val("single_rdy", 32'hB);
        got({28'h0, m_rdy_});
        expect_val("single_r_data", 32'hDEADBEEF);
        got(m_r_data);
        s_rdy_ = 1'b1;

        m_req_ = 4'b1110;
        expect_val("rr_park0", 32'hE);
        tick();
        got({28'h0, m_grnt_});
        m_req_ = 4'b0000;
        expect_val("rr_hold0", 32'hE);
        tick();
        got({28'h0, m_grnt_});
        for (int k = 0; k < 4; k++) begin
            m_req_[k] = 1'b1;
            expect_val($sformatf("rr_step%0d", k), {28'h0, ~(4'b0001 << ((k + 1) % 4))});
            tick();
            m_req_[k] = 1'b0;
            got({28'h0, m_grnt_});
        end

        m_req_ = 4'b0001;
        expect_val("hold_take1", 32'hD);
        tick();
        got({28'h0, m_grnt_});
        for (int k = 0; k < 50; k++) begin
            expect_val("hold_grant", 32'hD);
            tick();
            got({28'h0, m_grnt_});
        end

        m_req_ = 4'b0111;
        expect_val("to_grant3", 32'h7);
        tick();
        got({28'h0, m_grnt_});
        m_as_[3] = 1'b0;
        for (int k = 0; k < 7; k++) begin
            expect_val("to_wait_err", 32'h0);
            expect_val("to_wait_rdy", 32'h1);
            tick();
            got({31'h0, bus_err});
            got({31'h0, m_rdy_[3]});
        end
        expect_val("to_rdy", 32'h7);
        expect_val("to_r_data", 32'h0);
        expect_val("to_s_as", 32'h1);
        expect_val("to_bus_err", 32'h1);
        expect_val("to_err_master", 32'h3);
        tick();
        got({28'h0, m_rdy_});
        got(m_r_data);
        got({31'h0, s_as_});
        got({31'h0, bus_err});
        got({30'h0, err_master});
        m_as_[3] = 1'b1;
        expect_val("to_pulse_end", 32'h0);
        expect_val("to_rdy_release", 32'hF);
        tick();
        got({31'h0, bus_err});
        got({28'h0, m_rdy_});

        m_as_[3] = 1'b0;
        for (int k = 0; k < 7; k++) tick();
        s_rdy_ = 1'b0;
        #1;
        expect_val("race_rdy", 32'h7);
        got({28'h0, m_rdy_});
        expect_val("race_no_err", 32'h0);
        tick();
        s_rdy_ = 1'b1;
        m_as_[3] = 1'b1;
        got({31'h0, bus_err});
        expect_val("race_no_err_late", 32'h0);
        tick();
        got({31'h0, bus_err});

        m_req_ = 4'b1011;
        expect_val("mid_grant2", 32'hB);
        tick();
        got({28'h0, m_grnt_});
        m_as_[2] = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        rst = 1'b1;
        m_req_ = 4'hF;
        m_as_ = 4'hF;
        tick();
        rst = 1'b0;
        expect_val("mid_grant0", 32'hE);
        got({28'h0, m_grnt_});
        expect_val("mid_wd_cnt", 32'h0);
        got(32'(dut.u_wd.wd_cnt));
        expect_val("mid_rdy", 32'hF);
        got({28'h0, m_rdy_});
        for (int k = 0; k < 10; k++) begin
            expect_val("mid_no_err", 32'h0);
            tick();
            got({31'h0, bus_err});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
